// File: rtl/alu_operand_reg_if.sv
// Control strobes for the ALU operand register; the shared tri-state nets stay module-level wires.
interface alu_operand_reg_if;
    logic clr;
    logic in_en;
    logic out_en;
    logic alu_in;

    modport master (output clr, output in_en, output out_en, output alu_in);
    modport slave  (input  clr, input  in_en, input  out_en, input  alu_in);
endinterface

// File: rtl/alu_operand_reg.sv
// Operand register between the shared system data bus and the ALU operand bus.
// Latency: load visible on the next rising edge; both tri-state drivers are combinational.
// Backpressure: none, every strobe takes effect unconditionally.
module alu_operand_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_operand_reg_if.slave ctl,
    inout  wire [WIDTH-1:0]  data,
    output wire [WIDTH-1:0]  alu_data
);

    logic [WIDTH-1:0] q;

    // clr beats in_en; with out_en also set, the bus carries q so a load keeps q unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ctl.clr) begin
            q <= '0;
        end else if (ctl.in_en) begin
            q <= data;
        end
    end

    assign data     = ctl.out_en ? q : {WIDTH{1'bz}};
    assign alu_data = ctl.alu_in ? q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_operand_reg.sv
// Directed bench for alu_operand_reg; both buses carry pull-ups so an undriven bus reads 0xFF.
module tb_alu_operand_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       drv_en;
    logic [7:0] drv;
    wire  [7:0] data;
    wire  [7:0] alu_data;

    alu_operand_reg_if ctl ();

    alu_operand_reg #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl      (ctl.slave),
        .data     (data),
        .alu_data (alu_data)
    );

    assign data = drv_en ? drv : 8'bzzzz_zzzz;
    pullup (data[0]); pullup (data[1]); pullup (data[2]); pullup (data[3]);
    pullup (data[4]); pullup (data[5]); pullup (data[6]); pullup (data[7]);
    pullup (alu_data[0]); pullup (alu_data[1]); pullup (alu_data[2]); pullup (alu_data[3]);
    pullup (alu_data[4]); pullup (alu_data[5]); pullup (alu_data[6]); pullup (alu_data[7]);

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: the stored byte as the rules define it
    logic [7:0] model_q;
    always @(posedge clk or negedge rst) begin
        if (!rst)          model_q <= 8'h00;
        else if (ctl.clr)  model_q <= 8'h00;
        else if (ctl.in_en) model_q <= data;
    end

    logic cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_alu",  alu_data, ctl.alu_in ? model_q : 8'hFF);
            check("cyc_data", data,     ctl.out_en ? model_q : (drv_en ? drv : 8'hFF));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [7:0] v);
        drv = v; drv_en = 1'b1; ctl.in_en = 1'b1;
        tick();
        ctl.in_en = 1'b0; drv_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; drv_en = 1'b0; drv = 8'h00;
        ctl.clr = 1'b0; ctl.in_en = 1'b0; ctl.out_en = 1'b0; ctl.alu_in = 1'b0;
        #3;
        check("rst_alu_z",  alu_data, 8'hFF);
        check("rst_data_z", data,     8'hFF);
        ctl.alu_in = 1'b1; #1;
        check("rst_alu_zero", alu_data, 8'h00);
        ctl.alu_in = 1'b0;

        tick();
        rst = 1'b1; cmp_on = 1'b1;
        load(8'h33);
        ctl.alu_in = 1'b1; #1;
        check("load33", alu_data, 8'h33);

        // reset between edges must clear without a clock
        #1 rst = 1'b0; #1;
        check("async_rst", alu_data, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        check("rst_release_hold", alu_data, 8'h00);

        ctl.alu_in = 1'b0;
        load(8'hAA);
        #1;
        check("alu_off",       alu_data, 8'hFF);
        check("data_undriven", data,     8'hFF);
        ctl.alu_in = 1'b1; #1;
        check("alu_drive", alu_data, 8'hAA);
        tick();
        ctl.alu_in = 1'b0; #1;
        check("alu_released", alu_data, 8'hFF);

        ctl.out_en = 1'b1; #1;
        check("bus_drive", data, 8'hAA);
        ctl.in_en = 1'b1;
        tick();
        ctl.in_en = 1'b0; #1;
        check("load_while_drive", data, 8'hAA);
        ctl.alu_in = 1'b1; #1;
        check("both_en_alu",  alu_data, 8'hAA);
        check("both_en_data", data,     8'hAA);
        ctl.out_en = 1'b0; ctl.alu_in = 1'b0; #1;
        check("bus_released", data, 8'hFF);

        ctl.clr = 1'b1;
        tick();
        ctl.clr = 1'b0; ctl.alu_in = 1'b1; #1;
        check("clear", alu_data, 8'h00);

        load(8'hAA);
        ctl.clr = 1'b1; drv = 8'h77; drv_en = 1'b1; ctl.in_en = 1'b1;
        tick();
        ctl.clr = 1'b0; ctl.in_en = 1'b0; drv_en = 1'b0; #1;
        check("clr_priority", alu_data, 8'h00);

        ctl.alu_in = 1'b0;
        load(8'h5C);
        repeat (4) tick();
        check("hold_alu_z",  alu_data, 8'hFF);
        check("hold_data_z", data,     8'hFF);
        ctl.alu_in = 1'b1; #1;
        check("hold_value", alu_data, 8'h5C);
        ctl.out_en = 1'b1; #1;
        check("hold_bus", data, 8'h5C);
        ctl.out_en = 1'b0; ctl.alu_in = 1'b0;
        tick();

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
